// File: rtl/module_instr_encoder.sv
// Program loader: encodes decoded RV32I field bundles (lw, sw, R, beq, I-ALU, jal)
// and writes them to instruction memory at sequential word addresses.
module module_instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        type_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7b5_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [20:0]       imm_i,
    input  logic              last_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        fits12;
    logic        fits13;
    logic        accept;

    always_comb begin
        // Immediate fits when every bit above the sign bit replicates it.
        fits12    = (imm_i[20:11] == {10{imm_i[11]}});
        fits13    = (imm_i[20:12] == {9{imm_i[12]}});
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        case (type_i)
            3'd0: begin
                enc_word  = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
                enc_legal = fits12;
            end
            3'd1: begin
                enc_word  = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
                enc_legal = fits12;
            end
            3'd2: begin
                enc_word  = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
                enc_legal = 1'b1;
            end
            3'd3: begin
                enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                             imm_i[4:1], imm_i[11], 7'b1100011};
                enc_legal = fits13 & ~imm_i[0];
            end
            3'd4: begin
                enc_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
                enc_legal = fits12;
            end
            3'd5: begin
                enc_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
                enc_legal = ~imm_i[0];
            end
            default: begin
                enc_word  = 32'h0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // A start request always wins, so a coincident bundle is never taken.
    assign accept = (state_q == S_LOAD) & valid_i & ~start_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (enc_legal) begin
                        wdata_d = enc_word;
                        last_d  = last_i;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (addr_q == ADDR_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = state_q;
        endcase
        if (start_i) begin
            state_d = S_LOAD;
            addr_d  = BASE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            wdata_q <= 32'h0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
        end
    end

    assign ready_o = (state_q == S_LOAD);
    assign we_o    = (state_q == S_WRITE);
    assign busy_o  = (state_q == S_LOAD) | (state_q == S_WRITE);
    assign done_o  = (state_q == S_DONE);
    assign err_o   = (state_q == S_ERROR);
    assign waddr_o = addr_q;
    assign wdata_o = wdata_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_module_instr_encoder.sv
// Directed self-checking bench for module_instr_encoder: a 64-word instance for
// encoding/control scenarios and a 4-word instance for address overflow.
module tb_module_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, valid = 1'b0, last = 1'b0;
    logic        start2 = 1'b0, valid2 = 1'b0, last2 = 1'b0;
    logic [2:0]  ty = 3'd0, f3 = 3'd0;
    logic        f7 = 1'b0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [20:0] imm = 21'd0;

    logic        ready, we, busy, done, err;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [6:0]  count;
    logic        ready2, we2, busy2, done2, err2;
    logic [1:0]  waddr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    module_instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .valid_i(valid), .ready_o(ready),
        .type_i(ty), .funct3_i(f3), .funct7b5_i(f7), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .imm_i(imm), .last_i(last), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
        .count_o(count), .busy_o(busy), .done_o(done), .err_o(err)
    );

    module_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .valid_i(valid2), .ready_o(ready2),
        .type_i(ty), .funct3_i(f3), .funct7b5_i(f7), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .imm_i(imm), .last_i(last2), .we_o(we2), .waddr_o(waddr2), .wdata_o(wdata2),
        .count_o(count2), .busy_o(busy2), .done_o(done2), .err_o(err2)
    );

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
    endtask

    // Presents one bundle and waits (bounded) for it to be accepted; on return
    // after acceptance the time is 1 unit past the accepting clock edge.
    task automatic drive_bundle(input bit sel, input logic [2:0] t, input logic [2:0] fn3,
                                input logic fn7, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [20:0] im,
                                input logic lst, output bit ok);
        @(negedge clk);
        ty = t; f3 = fn3; f7 = fn7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        if (sel) begin last2 = lst; valid2 = 1'b1; end
        else begin last = lst; valid = 1'b1; end
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((sel ? ready2 : ready) === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        valid2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({ready, we, busy, done, err} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {ready, we, busy, done, err}); end
        checks++; if (waddr !== 6'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
        checks++; if (wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=00000000", wdata); end
        checks++; if (count !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", ready); end
    endtask

    task automatic test_lw();
        bit ok;
        pulse_start(1'b0);
        checks++; if ({ready, busy} !== 2'b11) begin failures++; $display("FAIL t1_load got=%b exp=11", {ready, busy}); end
        drive_bundle(1'b0, 3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 21'd8, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL t1_accept got=%b exp=1", ok); end
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL t1_we got=%b exp=1", we); end
        checks++; if (waddr !== 6'd0) begin failures++; $display("FAIL t1_waddr got=%0d exp=0", waddr); end
        checks++; if (wdata !== 32'h00812283) begin failures++; $display("FAIL t1_wdata got=%h exp=00812283", wdata); end
        @(posedge clk); #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL t1_we_pulse got=%b exp=0", we); end
        checks++; if (count !== 7'd1) begin failures++; $display("FAIL t1_count got=%0d exp=1", count); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL t1_back_to_load got=%b exp=1", ready); end
    endtask

    task automatic test_program();
        bit ok;
        logic [31:0] exp_w [3] = '{32'h00512623, 32'h002081B3, 32'h402081B3};
        pulse_start(1'b0);
        drive_bundle(1'b0, 3'd1, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 21'd12, 1'b0, ok);
        checks++; if (!ok || wdata !== exp_w[0] || waddr !== 6'd0 || we !== 1'b1) begin failures++; $display("FAIL t2_sw got=%h@%0d we=%b exp=%h@0", wdata, waddr, we, exp_w[0]); end
        drive_bundle(1'b0, 3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, ok);
        checks++; if (!ok || wdata !== exp_w[1] || waddr !== 6'd1 || we !== 1'b1) begin failures++; $display("FAIL t2_add got=%h@%0d we=%b exp=%h@1", wdata, waddr, we, exp_w[1]); end
        drive_bundle(1'b0, 3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, ok);
        checks++; if (!ok || wdata !== exp_w[2] || waddr !== 6'd2 || we !== 1'b1) begin failures++; $display("FAIL t2_sub got=%h@%0d we=%b exp=%h@2", wdata, waddr, we, exp_w[2]); end
        @(posedge clk); #1;
        checks++; if ({done, err, ready, busy} !== 4'b1000) begin failures++; $display("FAIL t2_done got=%b exp=1000", {done, err, ready, busy}); end
        checks++; if (count !== 7'd3) begin failures++; $display("FAIL t2_count got=%0d exp=3", count); end
    endtask

    task automatic test_branch_jal();
        bit ok;
        pulse_start(1'b0);
        drive_bundle(1'b0, 3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFFC, 1'b0, ok);
        checks++; if (!ok || wdata !== 32'hFE208EE3 || waddr !== 6'd0) begin failures++; $display("FAIL t3_beq got=%h@%0d exp=fe208ee3@0", wdata, waddr); end
        drive_bundle(1'b0, 3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd8, 1'b1, ok);
        checks++; if (!ok || wdata !== 32'h008000EF || waddr !== 6'd1) begin failures++; $display("FAIL t3_jal got=%h@%0d exp=008000ef@1", wdata, waddr); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || count !== 7'd2) begin failures++; $display("FAIL t3_done got=%b/%0d exp=1/2", done, count); end
    endtask

    task automatic test_illegal();
        bit ok;
        pulse_start(1'b0);
        drive_bundle(1'b0, 3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'h0007FF, 1'b0, ok);
        checks++; if (!ok || wdata !== 32'h7FF00093) begin failures++; $display("FAIL t4_imm_max got=%h exp=7ff00093", wdata); end
        drive_bundle(1'b0, 3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'h1FF800, 1'b0, ok);
        checks++; if (!ok || wdata !== 32'h80000093) begin failures++; $display("FAIL t4_imm_min got=%h exp=80000093", wdata); end
        drive_bundle(1'b0, 3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'h000800, 1'b0, ok);
        checks++; if (!ok || err !== 1'b1 || we !== 1'b0) begin failures++; $display("FAIL t4_imm2048 got=err%b we%b exp=err1 we0", err, we); end
        checks++; if (count !== 7'd2) begin failures++; $display("FAIL t4_count_held got=%0d exp=2", count); end
        pulse_start(1'b0);
        drive_bundle(1'b0, 3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd0, 1'b0, ok);
        checks++; if (!ok || err !== 1'b1 || we !== 1'b0 || count !== 7'd0) begin failures++; $display("FAIL t4_type7 got=err%b we%b cnt%0d exp=err1 we0 cnt0", err, we, count); end
        pulse_start(1'b0);
        drive_bundle(1'b0, 3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'd3, 1'b0, ok);
        checks++; if (!ok || err !== 1'b1 || we !== 1'b0) begin failures++; $display("FAIL t4_beq_odd got=err%b we%b exp=err1 we0", err, we); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL t4_err_hold got=err%b rdy%b exp=err1 rdy0", err, ready); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [31:0] exp_w;
        pulse_start(1'b1);
        for (int k = 0; k < 4; k++) begin
            drive_bundle(1'b1, 3'd0, 3'd0, 1'b0, 5'(k + 1), 5'd0, 5'd0, 21'd0, 1'b0, ok);
            exp_w = 32'h00002003 | (32'(k + 1) << 7);
            checks++; if (!ok || we2 !== 1'b1 || waddr2 !== 2'(k) || wdata2 !== exp_w) begin failures++; $display("FAIL t5_write%0d got=%h@%0d we=%b exp=%h@%0d", k, wdata2, waddr2, we2, exp_w, k); end
        end
        @(posedge clk); #1;
        checks++; if (err2 !== 1'b1 || count2 !== 3'd4 || waddr2 !== 2'd0) begin failures++; $display("FAIL t5_overflow got=err%b cnt%0d addr%0d exp=err1 cnt4 addr0", err2, count2, waddr2); end
        drive_bundle(1'b1, 3'd0, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 21'd0, 1'b0, ok);
        checks++; if (ok !== 1'b0 || we2 !== 1'b0 || count2 !== 3'd4) begin failures++; $display("FAIL t5_fifth got=acc%b we%b cnt%0d exp=acc0 we0 cnt4", ok, we2, count2); end
    endtask

    task automatic test_start_during_write();
        bit ok;
        pulse_start(1'b0);
        drive_bundle(1'b0, 3'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd0, 1'b0, ok);
        drive_bundle(1'b0, 3'd0, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 21'd0, 1'b0, ok);
        drive_bundle(1'b0, 3'd0, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 21'd0, 1'b0, ok);
        start = 1'b1;
        #1;
        checks++; if (!ok || we !== 1'b1 || waddr !== 6'd2) begin failures++; $display("FAIL t6_write_completes got=we%b addr%0d exp=we1 addr2", we, waddr); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (count !== 7'd0 || waddr !== 6'd0 || ready !== 1'b1 || we !== 1'b0) begin failures++; $display("FAIL t6_restart got=cnt%0d addr%0d rdy%b we%b exp=cnt0 addr0 rdy1 we0", count, waddr, ready, we); end
        @(negedge clk);
        ty = 3'd0; rd = 5'd4; imm = 21'd0; last = 1'b0;
        start = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; valid = 1'b0;
        checks++; if (we !== 1'b0 || ready !== 1'b1 || count !== 7'd0) begin failures++; $display("FAIL t6_start_beats_valid got=we%b rdy%b cnt%0d exp=we0 rdy1 cnt0", we, ready, count); end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        pulse_start(1'b0);
        drive_bundle(1'b0, 3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 21'd8, 1'b0, ok);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({ready, we, busy, done, err} !== 5'b0 || count !== 7'd0 || waddr !== 6'd0 || wdata !== 32'h0) begin failures++; $display("FAIL t6_async_reset got=%b cnt%0d addr%0d data%h exp=00000 cnt0 addr0 data0", {ready, we, busy, done, err}, count, waddr, wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t6_abandoned got=rdy%b busy%b exp=rdy0 busy0", ready, busy); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_program();
        test_branch_jal();
        test_illegal();
        test_overflow();
        test_start_during_write();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
